// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core (one instruction at a time).
// Optional MULTICYCLE_ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP until reset.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [6:0]         iOpcode,
    input  logic               iZero,
    input  logic               iMemReady,
    output logic               oPCWrite,
    output logic               oIRWrite,
    output logic               oAdrSrc,
    output logic               oMemWrite,
    output logic               oRegWrite,
    output logic [1:0]         oALUSrcA,
    output logic [1:0]         oALUSrcB,
    output logic [1:0]         oALUOp,
    output logic [1:0]         oResultSrc,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output logic               oIllegal,
`endif
    output logic [STATE_W-1:0] oState
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ANY = 2'b10;
    localparam logic [1:0] OP_FWD = 2'b11;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd12
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge iCLK) begin
        if (iRST) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        oPCWrite   = 1'b0;
        oIRWrite   = 1'b0;
        oAdrSrc    = 1'b0;
        oMemWrite  = 1'b0;
        oRegWrite  = 1'b0;
        oALUSrcA   = 2'b00;
        oALUSrcB   = 2'b00;
        oALUOp     = OP_ADD;
        oResultSrc = 2'b00;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        oIllegal   = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                oALUSrcB   = 2'b10;
                oResultSrc = 2'b10;
                if (iMemReady) begin
                    oIRWrite = 1'b1;
                    oPCWrite = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // oldPC + imm lands in ALUOut as the branch target
                oALUSrcA = 2'b01;
                oALUSrcB = 2'b01;
                case (iOpcode)
                    OPC_LW, OPC_SW: w_next = S_MEMADR;
                    OPC_R:          w_next = S_EXECR;
                    OPC_I:          w_next = S_EXECI;
                    OPC_BEQ:        w_next = S_BEQ;
                    OPC_JAL:        w_next = S_JAL;
                    OPC_LUI:        w_next = S_LUI;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:        w_next = S_TRAP;
`else
                    default:        w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                oALUSrcA = 2'b10;
                oALUSrcB = 2'b01;
                w_next   = (iOpcode == OPC_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                oAdrSrc = 1'b1;
                if (iMemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                oResultSrc = 2'b01;
                oRegWrite  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                oAdrSrc   = 1'b1;
                oMemWrite = 1'b1;
                if (iMemReady) w_next = S_FETCH;
            end
            S_EXECR: begin
                oALUSrcA = 2'b10;
                oALUOp   = OP_ANY;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                oALUSrcA = 2'b10;
                oALUSrcB = 2'b01;
                oALUOp   = OP_ANY;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                oRegWrite = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQ: begin
                oALUSrcA = 2'b10;
                oALUOp   = OP_SUB;
                oPCWrite = iZero;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                // jump target comes from ALUOut; ALU forms PC+4 for the link write
                oALUSrcA = 2'b01;
                oALUSrcB = 2'b10;
                oPCWrite = 1'b1;
                w_next   = S_ALUWB;
            end
            S_LUI: begin
                oALUSrcB = 2'b01;
                oALUOp   = OP_FWD;
                w_next   = S_ALUWB;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_TRAP: begin
                oIllegal = 1'b1;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    assign oState = r_state;

endmodule
